// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - RegFile writeback arbiter (ALU vs LSU) with load scoreboard and decode stall.
// Optional WB_FIXED_PRIO_EN: LSU always wins ties instead of round-robin.
module regfile_wb_arbiter #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ALU_VALID,
  input  logic [ADDR_W-1:0] ALU_RD,
  input  logic [XLEN-1:0]   ALU_DATA,
  output logic              ALU_READY,
  input  logic              LSU_VALID,
  input  logic [ADDR_W-1:0] LSU_RD,
  input  logic [XLEN-1:0]   LSU_DATA,
  output logic              LSU_READY,
  input  logic              LOAD_ISSUE,
  input  logic [ADDR_W-1:0] LOAD_ISSUE_RD,
  input  logic [ADDR_W-1:0] R1,
  input  logic [ADDR_W-1:0] R2,
  output logic              STALL,
  output logic [ADDR_W-1:0] RD,
  output logic [XLEN-1:0]   RD_DATA,
  output logic              REG_WRITE_ENABLE
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic             alu_grant;
  logic             lsu_grant;
  logic             load_set;

`ifdef WB_FIXED_PRIO_EN
  always_comb begin
    lsu_grant = LSU_VALID && !RESET;
    alu_grant = ALU_VALID && !LSU_VALID && !RESET;
  end
`else
  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LSU = 1'b1
  } grant_e;

  grant_e last_grant;
  grant_e last_grant_next;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    lsu_grant       = LSU_VALID && (!ALU_VALID || last_grant == GRANT_ALU) && !RESET;
    alu_grant       = ALU_VALID && (!LSU_VALID || last_grant == GRANT_LSU) && !RESET;
    last_grant_next = last_grant;
    if (lsu_grant) last_grant_next = GRANT_LSU;
    else if (alu_grant) last_grant_next = GRANT_ALU;
  end

  always_ff @(posedge CLK) begin
    if (RESET) last_grant <= GRANT_ALU;
    else       last_grant <= last_grant_next;
  end
`endif

  assign ALU_READY = alu_grant;
  assign LSU_READY = lsu_grant;

  // Stall uses the registered busy vector, so a clear becomes visible a cycle later.
  always_comb begin
    STALL = ((R1 != '0) && busy[R1]) ||
            ((R2 != '0) && busy[R2]) ||
            (LOAD_ISSUE && (LOAD_ISSUE_RD != '0) && busy[LOAD_ISSUE_RD]);
    load_set = LOAD_ISSUE && (LOAD_ISSUE_RD != '0) && !STALL;
  end

  // Clear first, then set, so a new load to the same register stays outstanding.
  always_comb begin
    busy_next = busy;
    if (lsu_grant) busy_next[LSU_RD] = 1'b0;
    if (load_set)  busy_next[LOAD_ISSUE_RD] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) busy <= '0;
    else       busy <= busy_next;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      RD               <= '0;
      RD_DATA          <= '0;
      REG_WRITE_ENABLE <= 1'b0;
    end else if (lsu_grant) begin
      RD               <= LSU_RD;
      RD_DATA          <= LSU_DATA;
      REG_WRITE_ENABLE <= (LSU_RD != '0);
    end else if (alu_grant) begin
      RD               <= ALU_RD;
      RD_DATA          <= ALU_DATA;
      REG_WRITE_ENABLE <= (ALU_RD != '0);
    end else begin
      REG_WRITE_ENABLE <= 1'b0;
    end
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single RegFile write port between two writeback requesters: the ALU and the load/store unit (LSU).
- Registers the winning write and drives the RegFile write port (RD, RD_DATA, REG_WRITE_ENABLE).
- Keeps a load scoreboard (one busy bit per register) and gives decode a STALL signal for read-after-load hazards.
- Sits between the execute/memory stages and RegFile in the RV32I core.

Parameters:
- XLEN, 32, data width of the register file.
- ADDR_W, 5, register address width; NREGS = 2**ADDR_W.

Ports:
- CLK  in  1  clock, all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- ALU_VALID  in  1  ALU writeback request.
- ALU_RD  in  ADDR_W  ALU destination register.
- ALU_DATA  in  XLEN  ALU result.
- ALU_READY  out  1  ALU request accepted this cycle.
- LSU_VALID  in  1  load writeback request.
- LSU_RD  in  ADDR_W  load destination register.
- LSU_DATA  in  XLEN  load data.
- LSU_READY  out  1  LSU request accepted this cycle.
- LOAD_ISSUE  in  1  a load is dispatched this cycle.
- LOAD_ISSUE_RD  in  ADDR_W  destination of the dispatched load.
- R1  in  ADDR_W  decode source register 1.
- R2  in  ADDR_W  decode source register 2.
- STALL  out  1  decode must hold.
- RD  out  ADDR_W  RegFile write address (registered).
- RD_DATA  out  XLEN  RegFile write data (registered).
- REG_WRITE_ENABLE  out  1  RegFile write strobe (registered).

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous, active-high, named RESET.
- Reset values:
  - RD = 0, RD_DATA = 0, REG_WRITE_ENABLE = 0.
  - Busy vector all 0.
  - Round-robin pointer last_grant = ALU, so the LSU wins the first tie.
- RESET mid-operation: any write held in the output register is dropped, so REG_WRITE_ENABLE = 0 the following cycle. A request presented during RESET is not accepted: both READY outputs are 0 while RESET = 1.
- Handshake:
  - A transfer occurs when VALID && READY.
  - READY is combinational from the VALIDs and last_grant. VALID must not depend on READY.
  - The requester holds RD and DATA stable while VALID && !READY.
- Arbitration: at most one grant per cycle.
  - Only one VALID: that requester is granted.
  - Both VALID: grant the requester that is not last_grant, then last_grant <= the winner.
  - No VALID: last_grant unchanged.
- Write latency: exactly 1 cycle. On the edge after a transfer:
  - RD <= granted rd, RD_DATA <= granted data, REG_WRITE_ENABLE <= (granted rd != 0).
- Idle cycle: REG_WRITE_ENABLE <= 0; RD and RD_DATA hold their previous values.
- x0 writes: the transfer completes (READY = 1), but no write strobe is produced.
- Scoreboard: busy[NREGS-1:0]; busy[0] is always 0.
  - Set: LOAD_ISSUE && LOAD_ISSUE_RD != 0 && !STALL sets busy[LOAD_ISSUE_RD].
  - Clear: an LSU transfer clears busy[LSU_RD].
  - Same register set and cleared in the same cycle: set wins (the new load is outstanding).
- STALL (combinational) = (R1 != 0 && busy[R1]) || (R2 != 0 && busy[R2]) || (LOAD_ISSUE && LOAD_ISSUE_RD != 0 && busy[LOAD_ISSUE_RD]).
  - A LOAD_ISSUE presented while STALL is high is ignored; decode re-presents it.
  - STALL does not see the clear from the current cycle's LSU transfer. It drops one cycle after the clear; no same-cycle forwarding.
- The ALU writing a busy register neither changes the scoreboard nor is blocked. Ordering is decode's responsibility.

Optional Feature:
- Macro: WB_FIXED_PRIO_EN.
- Defined: the LSU always wins when both requesters are VALID; last_grant logic is removed. An ALU request waits while LSU_VALID stays high.
- Undefined (default): round-robin as specified above.

Test Plan:
- Reset, then ALU_VALID = 1, ALU_RD = 3, ALU_DATA = 0x11 -> ALU_READY = 1 the same cycle; next cycle REG_WRITE_ENABLE = 1, RD = 3, RD_DATA = 0x11; the cycle after, REG_WRITE_ENABLE = 0.
- Both VALID for 3 cycles: ALU (rd 1, 0xA), LSU (rd 2, 0xB), each re-presenting the same payload after acceptance -> grant sequence LSU, ALU, LSU; writes (2, 0xB), (1, 0xA), (2, 0xB). With WB_FIXED_PRIO_EN: LSU, LSU, LSU, and ALU_READY = 0 throughout.
- ALU_VALID = 1, ALU_RD = 0, ALU_DATA = 0xFF -> ALU_READY = 1; REG_WRITE_ENABLE stays 0.
- LOAD_ISSUE, LOAD_ISSUE_RD = 5; next cycle R1 = 5 -> STALL = 1. LSU transfer with rd 5, 0x55 -> STALL = 0 one cycle later and RD = 5, RD_DATA = 0x55 written.
- busy[7] = 1; LSU transfer rd 7 plus LOAD_ISSUE rd 7 in the same cycle -> the issue is ignored (STALL = 1), busy[7] cleared. Then busy[6] = 1; LSU transfer rd 6 plus LOAD_ISSUE rd 6 with busy[6] cleared beforehand via a separate path -> set wins, busy[6] stays 1.
- Transfer accepted, RESET asserted on the next cycle -> REG_WRITE_ENABLE = 0, busy all 0, STALL = 0, both READY = 0 during reset.
